// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: cause codes, default
// vector addresses and the sequencer state encoding.
package exc_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } cause_e;

  localparam logic [31:0] VEC_OPCODE_DEF = 32'd253;
  localparam logic [31:0] VEC_OVF_DEF    = 32'd254;
  localparam logic [31:0] VEC_DIV0_DEF   = 32'd255;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    WAIT = 2'b10,
    LOAD = 2'b11
  } state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: opcode_invalid > div_zero > overflow,
// producing the cause code and the matching vector address.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF
) (
  input  logic        opcode_invalid,
  input  logic        overflow,
  input  logic        div_zero,
  output logic        hit,
  output logic [1:0]  cause,
  output logic [31:0] vec
);

  always_comb begin
    hit   = opcode_invalid | div_zero | overflow;
    cause = CAUSE_NONE;
    vec   = '0;
    if (opcode_invalid) begin
      cause = CAUSE_OPCODE;
      vec   = VEC_OPCODE;
    end else if (div_zero) begin
      cause = CAUSE_DIV0;
      vec   = VEC_DIV0;
    end else if (overflow) begin
      cause = CAUSE_OVF;
      vec   = VEC_OVF;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: latches cause/vector/EPC on a trigger, drives the
// vector address, waits MEM_WAIT cycles for memory, then loads the PC.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 2,
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_en,
  input  logic        opcode_invalid,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data,
  output logic [31:0] excpt_out,
  output logic        iord_exc,
  output logic        epc_write,
  output logic [31:0] epc_out,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic [1:0]  cause,
  output logic        busy
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] vec_q, vec_d;
  logic [1:0]  cause_q, cause_d;

  logic        enc_hit;
  logic [1:0]  enc_cause;
  logic [31:0] enc_vec;

  // Only the handler byte is consumed from the memory word.
  logic        mem_hi_unused;
  assign mem_hi_unused = |mem_data[31:8];

  exc_prio_enc #(
    .VEC_OPCODE (VEC_OPCODE),
    .VEC_OVF    (VEC_OVF),
    .VEC_DIV0   (VEC_DIV0)
  ) u_prio_enc (
    .opcode_invalid (opcode_invalid),
    .overflow       (overflow),
    .div_zero       (div_zero),
    .hit            (enc_hit),
    .cause          (enc_cause),
    .vec            (enc_vec)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    vec_d     = vec_q;
    cause_d   = cause_q;
    excpt_out = '0;
    iord_exc  = 1'b0;
    epc_write = 1'b0;
    pc_load   = 1'b0;
    pc_next   = '0;
    case (state_q)
      IDLE: begin
        if (exc_en && enc_hit) begin
          state_d = ADDR;
          cause_d = enc_cause;
          vec_d   = enc_vec;
          epc_d   = pc_in - 32'd4;
        end
      end
      ADDR: begin
        iord_exc  = 1'b1;
        excpt_out = vec_q;
        epc_write = 1'b1;
        cnt_d     = WAIT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        iord_exc  = 1'b1;
        excpt_out = vec_q;
        if (cnt_q == 4'd0) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LOAD: begin
        // Selector stays forced so mem_data still reflects the vector read.
        iord_exc  = 1'b1;
        excpt_out = vec_q;
        pc_load   = 1'b1;
        pc_next   = {24'b0, mem_data[7:0]};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      epc_q   <= '0;
      vec_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      vec_q   <= vec_d;
      cause_q <= cause_d;
    end
  end

  assign epc_out = epc_q;
  assign cause   = cause_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: default-latency instance plus MEM_WAIT=1/5
// instances sharing the same stimulus.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_en;
  logic        opcode_invalid;
  logic        overflow;
  logic        div_zero;
  logic [31:0] pc_in;
  logic [31:0] mem_data;

  logic [31:0] excpt_out, epc_out, pc_next;
  logic        iord_exc, epc_write, pc_load, busy;
  logic [1:0]  cause;

  logic [31:0] w1_excpt_out, w1_epc_out, w1_pc_next;
  logic        w1_iord_exc, w1_epc_write, w1_pc_load, w1_busy;
  logic [1:0]  w1_cause;

  logic [31:0] w5_excpt_out, w5_epc_out, w5_pc_next;
  logic        w5_iord_exc, w5_epc_write, w5_pc_load, w5_busy;
  logic [1:0]  w5_cause;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .exc_en(exc_en),
    .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
    .pc_in(pc_in), .mem_data(mem_data),
    .excpt_out(excpt_out), .iord_exc(iord_exc), .epc_write(epc_write),
    .epc_out(epc_out), .pc_load(pc_load), .pc_next(pc_next),
    .cause(cause), .busy(busy)
  );

  exc_ctrl #(.MEM_WAIT(1)) dut_w1 (
    .clk(clk), .reset(reset), .exc_en(exc_en),
    .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
    .pc_in(pc_in), .mem_data(mem_data),
    .excpt_out(w1_excpt_out), .iord_exc(w1_iord_exc), .epc_write(w1_epc_write),
    .epc_out(w1_epc_out), .pc_load(w1_pc_load), .pc_next(w1_pc_next),
    .cause(w1_cause), .busy(w1_busy)
  );

  exc_ctrl #(.MEM_WAIT(5)) dut_w5 (
    .clk(clk), .reset(reset), .exc_en(exc_en),
    .opcode_invalid(opcode_invalid), .overflow(overflow), .div_zero(div_zero),
    .pc_in(pc_in), .mem_data(mem_data),
    .excpt_out(w5_excpt_out), .iord_exc(w5_iord_exc), .epc_write(w5_epc_write),
    .epc_out(w5_epc_out), .pc_load(w5_pc_load), .pc_next(w5_pc_next),
    .cause(w5_cause), .busy(w5_busy)
  );

  always @(negedge clk) if (pc_load === 1'b1) load_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // {opcode_invalid, div_zero, overflow}
  task automatic set_flags(input logic [2:0] f);
    opcode_invalid = f[2];
    div_zero       = f[1];
    overflow       = f[0];
  endtask

  // Called right after the trigger edge; walks ADDR, WAIT x2, LOAD, IDLE.
  task automatic expect_seq(input string tag, input logic [1:0] c, input logic [31:0] v,
                            input logic [31:0] e, input logic [31:0] p,
                            input logic [2:0] fl_addr, input logic [2:0] fl_wait);
    set_flags(fl_addr);
    #3;
    chk({tag, "_addr_busy"},   32'(busy), 32'd1);
    chk({tag, "_addr_iord"},   32'(iord_exc), 32'd1);
    chk({tag, "_addr_epcw"},   32'(epc_write), 32'd1);
    chk({tag, "_addr_vec"},    excpt_out, v);
    chk({tag, "_addr_epc"},    epc_out, e);
    chk({tag, "_addr_cause"},  32'(cause), 32'(c));
    chk({tag, "_addr_pcload"}, 32'(pc_load), 32'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      set_flags(fl_wait);
      #3;
      chk({tag, "_wait_iord"},   32'(iord_exc), 32'd1);
      chk({tag, "_wait_vec"},    excpt_out, v);
      chk({tag, "_wait_epcw"},   32'(epc_write), 32'd0);
      chk({tag, "_wait_pcload"}, 32'(pc_load), 32'd0);
      chk({tag, "_wait_cause"},  32'(cause), 32'(c));
    end
    next_cycle();
    set_flags(3'b000);
    #3;
    chk({tag, "_load_pcload"}, 32'(pc_load), 32'd1);
    chk({tag, "_load_pcnext"}, pc_next, p);
    chk({tag, "_load_iord"},   32'(iord_exc), 32'd1);
    chk({tag, "_load_busy"},   32'(busy), 32'd1);
    next_cycle();
    #3;
    chk({tag, "_idle_busy"},   32'(busy), 32'd0);
    chk({tag, "_idle_iord"},   32'(iord_exc), 32'd0);
    chk({tag, "_idle_vec"},    excpt_out, 32'd0);
    chk({tag, "_idle_pcnext"}, pc_next, 32'd0);
    chk({tag, "_idle_cause"},  32'(cause), 32'(c));
    chk({tag, "_idle_epc"},    epc_out, e);
  endtask

  initial begin
    int lc0;
    int n_main, n_w1, n_w5;

    reset = 1'b1;
    exc_en = 1'b0;
    set_flags(3'b000);
    pc_in = '0;
    mem_data = '0;
    next_cycle();
    next_cycle();
    #3;
    chk("rst_excpt", excpt_out, 32'd0);
    chk("rst_iord",  32'(iord_exc), 32'd0);
    chk("rst_epcw",  32'(epc_write), 32'd0);
    chk("rst_epc",   epc_out, 32'd0);
    chk("rst_pcload", 32'(pc_load), 32'd0);
    chk("rst_pcnext", pc_next, 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);

    // Reset dominates a simultaneous trigger
    exc_en = 1'b1;
    set_flags(3'b111);
    next_cycle();
    set_flags(3'b000);
    #3;
    chk("rst_dom_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Overflow
    next_cycle();
    exc_en = 1'b1;
    set_flags(3'b001);
    pc_in = 32'h40;
    mem_data = 32'hDEAD_BE80;
    lc0 = load_cnt;
    next_cycle();
    expect_seq("ovf", 2'b10, 32'd254, 32'h3C, 32'h80, 3'b000, 3'b000);
    chk("ovf_loads", 32'(load_cnt - lc0), 32'd1);

    // All three flags: opcode wins; lower flags held through the sequence
    set_flags(3'b111);
    pc_in = 32'h1000;
    mem_data = 32'h0000_0020;
    next_cycle();
    expect_seq("sim", 2'b01, 32'd253, 32'hFFC, 32'h20, 3'b011, 3'b011);

    // Flags while busy are ignored
    set_flags(3'b010);
    pc_in = 32'h88;
    mem_data = 32'h0000_0033;
    lc0 = load_cnt;
    next_cycle();
    expect_seq("busy", 2'b11, 32'd255, 32'h84, 32'h33, 3'b010, 3'b100);
    next_cycle();
    #3;
    chk("busy_loads", 32'(load_cnt - lc0), 32'd1);
    chk("busy_idle2", 32'(busy), 32'd0);

    // Reset during WAIT
    set_flags(3'b100);
    pc_in = 32'h500;
    lc0 = load_cnt;
    next_cycle();
    set_flags(3'b000);   // ADDR
    next_cycle();        // WAIT
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #3;
    chk("mid_busy",   32'(busy), 32'd0);
    chk("mid_iord",   32'(iord_exc), 32'd0);
    chk("mid_excpt",  excpt_out, 32'd0);
    chk("mid_epc",    epc_out, 32'd0);
    chk("mid_cause",  32'(cause), 32'd0);
    chk("mid_pcload", 32'(pc_load), 32'd0);
    next_cycle();
    next_cycle();
    #3;
    chk("mid_loads",  32'(load_cnt - lc0), 32'd0);
    set_flags(3'b010);
    pc_in = 32'h100;
    mem_data = 32'h0000_0044;
    next_cycle();
    expect_seq("fresh", 2'b11, 32'd255, 32'hFC, 32'h44, 3'b000, 3'b000);

    // Gated flags
    exc_en = 1'b0;
    set_flags(3'b111);
    lc0 = load_cnt;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #3;
      chk("gate_busy", 32'(busy), 32'd0);
    end
    chk("gate_epc", epc_out, 32'hFC);
    chk("gate_loads", 32'(load_cnt - lc0), 32'd0);

    // EPC wrap
    exc_en = 1'b1;
    set_flags(3'b001);
    pc_in = 32'h0;
    mem_data = 32'h0000_00A5;
    next_cycle();
    expect_seq("wrap", 2'b10, 32'd254, 32'hFFFF_FFFC, 32'hA5, 3'b000, 3'b000);

    // Latency sweep across MEM_WAIT = 2 / 1 / 5
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    set_flags(3'b001);
    pc_in = 32'h200;
    mem_data = 32'h0000_0011;
    next_cycle();
    set_flags(3'b000);
    n_main = 0; n_w1 = 0; n_w5 = 0;
    for (int n = 1; n <= 12; n++) begin
      #3;
      if (pc_load && n_main == 0) n_main = n;
      if (w1_pc_load && n_w1 == 0) begin
        n_w1 = n;
        chk("w1_pcnext", w1_pc_next, 32'h11);
      end
      if (w5_pc_load && n_w5 == 0) begin
        n_w5 = n;
        chk("w5_pcnext", w5_pc_next, 32'h11);
      end
      next_cycle();
    end
    chk("lat_w2", 32'(n_main), 32'd4);
    chk("lat_w1", 32'(n_w1), 32'd3);
    chk("lat_w5", 32'(n_w5), 32'd7);
    #3;
    chk("w5_idle_busy", 32'(w5_busy), 32'd0);
    chk("w1_cause", 32'(w1_cause), 32'd2);
    chk("w5_epc", w5_epc_out, 32'h1FC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
